// File: rtl/ramb4_arb_pkg.sv
// Shared types for the two-port RAMB4_S4 arbiter: FSM states, requester ids, pipeline tags.
package ramb4_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEF_DATA_W = 4;

    typedef enum logic [0:0] {
        ST_SCRUB = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    typedef enum logic {
        ID_A = 1'b0,
        ID_B = 1'b1
    } req_id_t;

    typedef struct packed {
        logic    vld;
        logic    rd;
        req_id_t id;
    } stage_t;

endpackage

// File: rtl/ramb4_s4_arb2_rr_arb2.sv
// Two-way round-robin grant with a "last granted" pointer; grants are combinational.
module rr_arb2
    import ramb4_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    input  logic       busy,
    output logic [1:0] gnt
);

    req_id_t last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= ID_B;
        end else if (accept) begin
            last <= gnt[1] ? ID_B : ID_A;
        end
    end

    // On a tie the requester that was not granted last wins.
    always_comb begin
        gnt = '0;
        if (!busy) begin
            if (req == 2'b11) begin
                gnt = (last == ID_B) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/ramb4_s4_arb2.sv
// Round-robin arbiter/sequencer for one 1024x4 single-port block RAM, two requesters.
// Optional zero-fill scrub after reset when RAMB4_ARB_SCRUB_EN is defined.
module ramb4_s4_arb2
    import ramb4_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              A_REQ,
    input  logic              A_WE,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [DATA_W-1:0] A_DI,
    output logic              A_GNT,
    output logic              A_RVALID,
    output logic [DATA_W-1:0] A_DO,
    input  logic              B_REQ,
    input  logic              B_WE,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic [DATA_W-1:0] B_DI,
    output logic              B_GNT,
    output logic              B_RVALID,
    output logic [DATA_W-1:0] B_DO,
    output logic              RAM_EN,
    output logic              RAM_WE,
    output logic              RAM_RST,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [DATA_W-1:0] RAM_DI,
    input  logic [DATA_W-1:0] RAM_DO,
    output logic              BUSY
);

    if (DEPTH != (32'd1 << ADDR_W)) begin : g_depth_check
        $error("DEPTH must equal 2**ADDR_W");
    end

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              accept;
    logic              busy_int;
    logic              hold;
    req_id_t           acc_id;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_di;
    stage_t            s1;
    stage_t            s2;

    assign req     = {B_REQ, A_REQ};
    // Grants are suppressed combinationally while reset is asserted, not just after it.
    assign hold    = busy_int | ~RST_N;
    assign accept  = |(req & gnt);
    assign acc_id  = gnt[1] ? ID_B : ID_A;
    assign acc_we  = gnt[1] ? B_WE : A_WE;
    assign acc_addr = gnt[1] ? B_ADDR : A_ADDR;
    assign acc_di  = gnt[1] ? B_DI : A_DI;
    assign A_GNT   = gnt[0];
    assign B_GNT   = gnt[1];
    assign RAM_RST = 1'b0;
    assign BUSY    = busy_int;

    rr_arb2 u_arb (
        .clk    (CLK),
        .rst_n  (RST_N),
        .req    (req),
        .accept (accept),
        .busy   (hold),
        .gnt    (gnt)
    );

`ifdef RAMB4_ARB_SCRUB_EN
    state_t            state;
    logic [ADDR_W-1:0] scrub_addr;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_SCRUB;
            scrub_addr <= '0;
        end else if (state == ST_SCRUB) begin
            scrub_addr <= scrub_addr + ADDR_W'(1);
            if (scrub_addr == ADDR_W'(DEPTH - 1)) begin
                state <= ST_RUN;
            end
        end
    end

    assign busy_int = (state == ST_SCRUB);
`else
    assign busy_int = 1'b0;
`endif

    // Stage 1: registered RAM command plus the tag that follows it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RAM_EN   <= 1'b0;
            RAM_WE   <= 1'b0;
            RAM_ADDR <= '0;
            RAM_DI   <= '0;
            s1       <= '0;
        end else begin
            RAM_EN <= 1'b0;
            RAM_WE <= 1'b0;
            s1     <= '0;
            if (accept) begin
                RAM_EN   <= 1'b1;
                RAM_WE   <= acc_we;
                RAM_ADDR <= acc_addr;
                RAM_DI   <= acc_di;
                s1       <= '{vld: 1'b1, rd: ~acc_we, id: acc_id};
            end
`ifdef RAMB4_ARB_SCRUB_EN
            else if (busy_int) begin
                RAM_EN   <= 1'b1;
                RAM_WE   <= 1'b1;
                RAM_ADDR <= scrub_addr;
                RAM_DI   <= '0;
            end
`endif
        end
    end

    // Stages 2 and 3: RAM_DO is valid while s2 holds the tag; route it to its owner.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s2       <= '0;
            A_RVALID <= 1'b0;
            B_RVALID <= 1'b0;
            A_DO     <= '0;
            B_DO     <= '0;
        end else begin
            s2       <= s1;
            A_RVALID <= 1'b0;
            B_RVALID <= 1'b0;
            if (s2.vld && s2.rd) begin
                if (s2.id == ID_A) begin
                    A_RVALID <= 1'b1;
                    A_DO     <= RAM_DO;
                end else begin
                    B_RVALID <= 1'b1;
                    B_DO     <= RAM_DO;
                end
            end
        end
    end

endmodule

// File: tb/tb_ramb4_s4_arb2.sv
// Scoreboard bench for ramb4_s4_arb2 with a behavioural 1024x4 RAM; covers both scrub builds.
module tb_ramb4_s4_arb2;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned DEPTH  = 1024;
`ifdef RAMB4_ARB_SCRUB_EN
    localparam int SCRUB_CYC = 1024;
`else
    localparam int SCRUB_CYC = 0;
`endif

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              A_REQ = 1'b0, A_WE = 1'b0, B_REQ = 1'b0, B_WE = 1'b0;
    logic [ADDR_W-1:0] A_ADDR = '0, B_ADDR = '0;
    logic [DATA_W-1:0] A_DI = '0, B_DI = '0;
    logic              A_GNT, A_RVALID, B_GNT, B_RVALID;
    logic [DATA_W-1:0] A_DO, B_DO;
    logic              RAM_EN, RAM_WE, RAM_RST, BUSY;
    logic [ADDR_W-1:0] RAM_ADDR;
    logic [DATA_W-1:0] RAM_DI;
    logic [DATA_W-1:0] RAM_DO = '0;

    logic [DATA_W-1:0] mem [DEPTH];

    typedef struct packed {
        logic        id;
        logic [3:0]  data;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          scrub_left = SCRUB_CYC;
    int          en_cnt = 0;
    int          busy_cnt = 0;
    logic        model_last = 1'b1;
    logic [3:0]  exp_a_do = '0;
    logic [3:0]  exp_b_do = '0;

    ramb4_s4_arb2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_DI(A_DI),
        .A_GNT(A_GNT), .A_RVALID(A_RVALID), .A_DO(A_DO),
        .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_DI(B_DI),
        .B_GNT(B_GNT), .B_RVALID(B_RVALID), .B_DO(B_DO),
        .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_RST(RAM_RST),
        .RAM_ADDR(RAM_ADDR), .RAM_DI(RAM_DI), .RAM_DO(RAM_DO),
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Write-first single-port RAM
    always @(posedge CLK) begin
        if (RAM_EN) begin
            if (RAM_WE) begin
                mem[RAM_ADDR] <= RAM_DI;
                RAM_DO        <= RAM_DI;
            end else begin
                RAM_DO <= mem[RAM_ADDR];
            end
        end
    end

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) scrub_left <= SCRUB_CYC;
        else if (scrub_left > 0) scrub_left <= scrub_left - 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: arbiter model, output hold, and scoreboard pops on RVALID.
    always @(negedge CLK) begin
        logic [1:0] exp_gnt;
        logic       busy_exp;
        exp_t       e;
        busy_exp = (scrub_left != 0);
        chk("ram_rst", 32'(RAM_RST), 32'd0);
        chk("busy", 32'(BUSY), 32'(busy_exp));
        if (!RST_N) begin
            chk("reset_outputs", 32'({A_GNT, B_GNT, A_RVALID, B_RVALID, A_DO, B_DO,
                                      RAM_EN, RAM_WE, RAM_ADDR, RAM_DI}), 32'd0);
            model_last = 1'b1;
            exp_a_do   = '0;
            exp_b_do   = '0;
            sbq.delete();
        end else begin
            if (BUSY) busy_cnt++;
            if (RAM_EN) en_cnt++;
            exp_gnt = 2'b00;
            if (!busy_exp) begin
                if (A_REQ && B_REQ) exp_gnt = model_last ? 2'b01 : 2'b10;
                else exp_gnt = {B_REQ, A_REQ};
            end
            chk("gnt", 32'({B_GNT, A_GNT}), 32'(exp_gnt));
            if (exp_gnt[0]) model_last = 1'b0;
            else if (exp_gnt[1]) model_last = 1'b1;
            if (A_RVALID || B_RVALID) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_rvalid", 32'({B_RVALID, A_RVALID}), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("rvalid_owner", 32'({B_RVALID, A_RVALID}), e.id ? 32'd2 : 32'd1);
                    chk("rd_data", 32'(e.id ? B_DO : A_DO), 32'(e.data));
                    chk("rd_latency", cyc - e.cyc, 32'd3);
                    if (e.id) exp_b_do = e.data;
                    else exp_a_do = e.data;
                end
            end
            chk("a_do", 32'(A_DO), 32'(exp_a_do));
            chk("b_do", 32'(B_DO), 32'(exp_b_do));
        end
    end

    task automatic drive(input logic id, input logic r, input logic we,
                         input logic [9:0] addr, input logic [3:0] di);
        if (id) begin
            B_REQ = r; B_WE = we; B_ADDR = addr; B_DI = di;
        end else begin
            A_REQ = r; A_WE = we; A_ADDR = addr; A_DI = di;
        end
    endtask

    // Holds the request until granted; reads push their hand-computed result.
    task automatic do_req(input logic id, input logic we, input logic [9:0] addr,
                          input logic [3:0] di, input logic [3:0] exp_d, input bit track);
        bit done = 1'b0;
        int waits = 0;
        drive(id, 1'b1, we, addr, di);
        while (!done) begin
            @(negedge CLK);
            if (RST_N && (id ? B_GNT : A_GNT)) begin
                done = 1'b1;
                if (!we && track) sbq.push_back('{id: id, data: exp_d, cyc: 32'(cyc)});
            end else if (++waits > 1200) begin
                checks++;
                errors++;
                $display("FAIL grant_timeout: requester %0d waited %0d cycles, limit 1200", id, waits);
                done = 1'b1;
            end
            @(posedge CLK);
            #1;
        end
        drive(id, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        int c0;
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = 4'hF;
`ifdef RAMB4_ARB_SCRUB_EN
        drive(1'b0, 1'b1, 1'b0, 10'h000, 4'h0);
`else
        drive(1'b0, 1'b1, 1'b1, 10'h000, 4'h5);
`endif
        idle(3);
        RST_N = 1'b1;

        // Scrub build: requests wait out BUSY, then scrubbed words read 0.
        // Plain build: A is granted in the first cycle after reset.
`ifdef RAMB4_ARB_SCRUB_EN
        do_req(1'b0, 1'b0, 10'h000, 4'h0, 4'h0, 1'b1);
        do_req(1'b0, 1'b0, 10'h200, 4'h0, 4'h0, 1'b1);
        do_req(1'b0, 1'b0, 10'h3FF, 4'h0, 4'h0, 1'b1);
`else
        do_req(1'b0, 1'b1, 10'h000, 4'h5, 4'h0, 1'b0);
        do_req(1'b0, 1'b0, 10'h000, 4'h0, 4'h5, 1'b1);
`endif
        idle(5);
        chk("busy_cycles", busy_cnt, SCRUB_CYC);

        // Write then read back-to-back; RAM enabled exactly two cycles.
        en_cnt = 0;
        do_req(1'b0, 1'b1, 10'h155, 4'hA, 4'h0, 1'b0);
        do_req(1'b0, 1'b0, 10'h155, 4'h0, 4'hA, 1'b1);
        idle(6);
        chk("ram_en_cycles", en_cnt, 2);

        // Both requesting: alternating grants, one accept per cycle.
        do_req(1'b0, 1'b1, 10'h001, 4'h1, 4'h0, 1'b0);
        do_req(1'b1, 1'b1, 10'h002, 4'h2, 4'h0, 1'b0);
        idle(2);
        c0 = cyc;
        fork
            repeat (4) do_req(1'b0, 1'b0, 10'h001, 4'h0, 4'h1, 1'b1);
            repeat (4) do_req(1'b1, 1'b0, 10'h002, 4'h0, 4'h2, 1'b1);
        join
        chk("tie_throughput", cyc - c0, 32'd8);
        idle(5);

        // B writes, A reads same address in the very next cycle.
        do_req(1'b1, 1'b1, 10'h010, 4'h3, 4'h0, 1'b0);
        do_req(1'b0, 1'b0, 10'h010, 4'h0, 4'h3, 1'b1);
        idle(5);

        // Read in flight when reset hits: no RVALID; first tie after reset to A.
        do_req(1'b0, 1'b0, 10'h155, 4'h0, 4'h0, 1'b0);
        idle(1);
        RST_N = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 10'h020, 4'h7);
        drive(1'b1, 1'b1, 1'b1, 10'h021, 4'h8);
        idle(2);
        RST_N = 1'b1;
        fork
            do_req(1'b0, 1'b1, 10'h020, 4'h7, 4'h0, 1'b0);
            do_req(1'b1, 1'b1, 10'h021, 4'h8, 4'h0, 1'b0);
        join
        do_req(1'b0, 1'b0, 10'h020, 4'h0, 4'h7, 1'b1);
        do_req(1'b1, 1'b0, 10'h021, 4'h0, 4'h8, 1'b1);
        idle(6);

        chk("scoreboard_drained", sbq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ramb4_s4_arb2.md
Name: ramb4_s4_arb2

Overview:
Two-requester round-robin arbiter and sequencer for one 1024x4 single-port block RAM (ramb4_s4-class port: EN, WE, RST, ADDR, DI, DO).
- Accepts read/write requests from ports A and B using a req/gnt handshake.
- Drives registered RAM commands and returns read data to the originating requester with a valid strobe.
- Sits between the two client datapaths and the RAM primitive instance.

Parameters:
ADDR_W, 10, RAM word address width (1024 words)
DATA_W, 4, RAM data width
DEPTH, 1024, word count; must equal 2**ADDR_W

Ports:
CLK  in  1  rising-edge clock, shared with RAM
RST_N  in  1  asynchronous active-low reset
A_REQ  in  1  requester A request
A_WE  in  1  1 = write, 0 = read
A_ADDR  in  ADDR_W  A word address
A_DI  in  DATA_W  A write data
A_GNT  out  1  A request accepted this cycle
A_RVALID  out  1  A read data valid (one-cycle pulse)
A_DO  out  DATA_W  A read data
B_REQ, B_WE, B_ADDR, B_DI, B_GNT, B_RVALID, B_DO: same as A, for requester B
RAM_EN  out  1  RAM enable
RAM_WE  out  1  RAM write enable
RAM_RST  out  1  RAM output-latch reset; constant 0
RAM_ADDR  out  ADDR_W  RAM address
RAM_DI  out  DATA_W  RAM write data
RAM_DO  in  DATA_W  RAM read data
BUSY  out  1  scrub in progress; requests are not granted

Behaviour:
- Reset (RST_N=0, asynchronous):
  - A_GNT, B_GNT, A_RVALID, B_RVALID forced 0.
  - A_DO, B_DO, RAM_EN, RAM_WE, RAM_ADDR, RAM_DI all 0.
  - RAM_RST = 0.
  - Round-robin pointer set to "last = B".
  - Pipeline valid bits cleared.
  - BUSY = 1 if RAMB4_ARB_SCRUB_EN is defined, otherwise 0.
- Handshake:
  - A requester holds REQ, WE, ADDR and DI stable until it sees GNT=1.
  - A transfer is accepted on the rising edge where REQ and GNT are both 1.
  - GNT is combinational from REQ, the pointer and the state.
  - GNT is 0 while BUSY=1 or while RST_N=0.
  - At most one GNT is high per cycle.
- Arbitration:
  - If only one requester is requesting, it is granted every cycle.
  - If both are requesting, the requester not granted last wins; the pointer updates on each accept.
  - After reset, the first tie goes to A.
  - Throughput: one accepted request per cycle; no bubbles.
- Pipeline (accept at edge E0):
  - Stage 1: RAM_EN=1, RAM_WE, RAM_ADDR and RAM_DI registered at E0 and driven during the next cycle; the RAM samples them at E1.
  - Stage 2: the requester id and a read flag follow in pipeline registers; RAM_DO is valid after E1.
  - Stage 3: at E2, RAM_DO is captured into the requester's xDO and xRVALID=1 for one cycle.
  - Read latency: RVALID is high in the third cycle after the accept cycle.
  - Writes produce no RVALID.
  - RAM_EN=0 and RAM_WE=0 in any cycle with no issued command.
  - xDO holds its last value when RVALID=0.
- Hazards:
  - A read accepted the cycle after a write to the same address returns the new data. This follows from RAM ordering; no forwarding is needed.
  - Write-first DO during writes is ignored.
- Reset mid-operation: in-flight reads are dropped, no RVALID is produced, and the pointer resets.
- Address wrap: none. Every ADDR value is legal.

Optional Feature:
Macro RAMB4_ARB_SCRUB_EN.
- Defined:
  - The FSM has states SCRUB and RUN; reset enters SCRUB with counter 0.
  - In SCRUB, one write of 0 is issued per cycle to RAM_ADDR = counter, for addresses 0..DEPTH-1, with BUSY=1 and no grants.
  - After the write to DEPTH-1 is issued, BUSY drops on the next cycle and the FSM enters RUN.
  - Scrub takes DEPTH cycles.
  - A reset during SCRUB restarts the scrub from address 0.
- Undefined: reset enters RUN directly, BUSY is tied to 0, and no counter is instantiated.

Decomposition:
- Package ramb4_arb_pkg:
  - ADDR_W and DATA_W defaults.
  - State enum {ST_SCRUB, ST_RUN}.
  - Requester id typedef (ID_A=0, ID_B=1).
  - Pipeline-stage struct {vld, rd, id}.
- Sub-module rr_arb2: two-way round-robin grant logic with the pointer register; inputs req[1:0], accept, busy; output gnt[1:0].

Test Plan:
1. No scrub. A write ADDR=0x155, DI=0xA; then A read 0x155 → A_RVALID in the third cycle after accept, A_DO=0xA; B_RVALID stays 0; RAM_EN high for exactly 2 cycles.
2. A_REQ and B_REQ both held high for reads (A at 0x001, B at 0x002, preloaded 0x1 and 0x2) → grants A,B,A,B…; RVALIDs alternate with DO 0x1/0x2; no cycle has both GNTs high.
3. B writes 0x3 to 0x010 at cycle T; A reads 0x010 at T+1 → A_DO=0x3.
4. A read accepted, then RST_N low one cycle later → no A_RVALID; all outputs 0 during reset; after reset, the first tie goes to A.
5. RAMB4_ARB_SCRUB_EN defined, RAM model preloaded with 0xF → BUSY=1 for 1024 cycles and GNT=0 despite A_REQ=1; afterwards reads of 0x000, 0x200 and 0x3FF return 0x0.
6. RAMB4_ARB_SCRUB_EN undefined → BUSY=0, and A_GNT=1 in the first cycle after RST_N rises with A_REQ=1.
